// File: rtl/prog_sequencer.sv
// Run controller: launches programs on Start falling edge, steers PC increment/branch loads, stops on Halt.
// PCEn/PCLoad/PCLoadVal are combinational (zero latency); status outputs registered; no backpressure.
module prog_sequencer #(
    parameter int L      = 10,
    parameter int NPROG  = 3,
    parameter int ENTRY0 = 0,
    parameter int ENTRY1 = 190,
    parameter int ENTRY2 = 200
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Halt,
    input  logic         BranchTaken,
    input  logic         BranchUp,
    input  logic [7:0]   PCTarget,
    input  logic [L-1:0] PCNow,
    output logic         PCEn,
    output logic         PCLoad,
    output logic [L-1:0] PCLoadVal,
    output logic [1:0]   ProgNum,
    output logic         Running,
    output logic         Done,
    output logic [15:0]  CycleCount,
    output logic         Err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOAD,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t       state_q, state_d;
    logic         start_q, start_d;
    logic [1:0]   prog_num_q, prog_num_d;
    logic [15:0]  cycle_cnt_q, cycle_cnt_d;
    logic         err_q, err_d;

    logic         rise, fall;
    logic         pc_en, pc_load;
    logic [L-1:0] pc_load_val;
    logic [L-1:0] entry_pc;
    logic [L-1:0] tgt_ext;

    always_comb begin
        entry_pc = '0;
        case (prog_num_q)
            2'd0:    entry_pc = L'(ENTRY0);
            2'd1:    entry_pc = L'(ENTRY1);
            2'd2:    entry_pc = L'(ENTRY2);
            default: entry_pc = '0;
        endcase
    end

    assign tgt_ext = L'(PCTarget);
    assign rise    = Start & ~start_q;
    assign fall    = ~Start & start_q;

    always_comb begin
        state_d     = state_q;
        start_d     = Start;
        prog_num_d  = prog_num_q;
        cycle_cnt_d = cycle_cnt_q;
        err_d       = err_q;
        pc_en       = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (rise) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (fall) begin
                    if (int'(prog_num_q) < NPROG) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                pc_load     = 1'b1;
                pc_load_val = entry_pc;
                prog_num_d  = prog_num_q + 2'd1;
                cycle_cnt_d = '0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (cycle_cnt_q != 16'hFFFF) cycle_cnt_d = cycle_cnt_q + 16'd1;
                if (rise) err_d = 1'b1;
                // Halt freezes the PC on the halt instruction even if a branch is also flagged
                if (Halt) begin
                    state_d = ST_HALTED;
                end else if (BranchTaken) begin
                    pc_load     = 1'b1;
                    pc_load_val = BranchUp ? (PCNow - tgt_ext) : (PCNow + tgt_ext);
                end else begin
                    pc_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            prog_num_q  <= '0;
            cycle_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            prog_num_q  <= prog_num_d;
            cycle_cnt_q <= cycle_cnt_d;
            err_q       <= err_d;
        end
    end

    // PC control is held off while Reset is asserted so the PC never moves during reset
    assign PCEn       = pc_en & ~Reset;
    assign PCLoad     = pc_load & ~Reset;
    assign PCLoadVal  = Reset ? '0 : pc_load_val;
    assign ProgNum    = prog_num_q;
    assign Running    = (state_q == ST_RUN);
    assign Done       = (state_q == ST_HALTED);
    assign CycleCount = cycle_cnt_q;
    assign Err        = err_q;

endmodule
